imem_boot_loader: RTL and testbench

Instruction-memory block directly upstream of the pipelined core. Receives a program over a byte-wide valid/ready stream and writes it into a word-addressed instruction RAM. Holds the core in reset until a checksum-verified load completes, then serves `instrF` combinationally from `PCF`. Also supports skipping the load to run the existing RAM contents.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/imem_boot_loader_if.sv | 12 +
 rtl/imem_ram.sv | 29 ++
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Definitions shared between the instruction-memory boot loader and the
//   core: the canonical NOP encoding and the loader state type.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } loader_state_e;

    // True while the loader still consumes bytes from the stream.
    function automatic logic is_loading(input loader_state_e s);
        return (s != S_RUN) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Byte-wide valid/ready stream carrying the program frame into the loader.
//   rx_valid / rx_data : driven by the byte source (master)
//   rx_ready           : driven by the loader (slave)
interface imem_boot_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input  rx_ready);
    modport slave  (input  rx_valid, input  rx_data, output rx_ready);
endinterface

// File: rtl/imem_ram.sv
// imem_ram
//   Word-addressed instruction RAM, 2^AW x 32 bits.
//   clk           : write clock (rising edge)
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port (feeds the core's fetch path)
module imem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset; contents must survive a loader reset so
    // that a skipped load can run the previously loaded program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program frame (LEN_LO, LEN_HI, N*4 data bytes, XOR checksum)
//   over a byte stream, writes it into the instruction RAM and releases the
//   core from reset once the checksum matches. Fetches are served
//   combinationally from PCF while running; a NOP is returned otherwise.
//   clk, rst      : clock, asynchronous active-low reset
//   rx            : byte stream (slave side)
//   boot_skip     : start the core on the current RAM contents
//   PCF / instrF  : core fetch byte address / instruction
//   core_rst_n    : active-low core reset
//   done / err    : load complete / load failed
//   words_loaded  : words written during the current load
module imem_boot_loader
    import riscv_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   rx,
    input  logic                boot_skip,
    input  logic [31:0]         PCF,
    output logic [31:0]         instrF,
    output logic                core_rst_n,
    output logic                done,
    output logic                err,
    output logic [AW:0]         words_loaded
);

    localparam logic [AW:0] WORD_INC = 1;

    loader_state_e state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    lane_cnt_q, lane_cnt_d;
    logic [23:0]   word_buf_q, word_buf_d;   // lanes 0..2 of the word in flight
    logic [7:0]    csum_q, csum_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [15:0]   new_len;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          unused_pcf_bits;

    assign rx.rx_ready = is_loading(state_q);
    assign accept      = rx.rx_valid && rx.rx_ready;

    // NOTE: every signal written here is defaulted first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        lane_cnt_d     = lane_cnt_q;
        word_buf_d     = word_buf_q;
        csum_d         = csum_q;
        words_loaded_d = words_loaded_q;
        ram_we         = 1'b0;
        ram_wdata      = {rx.rx_data, word_buf_q};
        new_len        = {rx.rx_data, len_q[7:0]};

        case (state_q)
            S_LEN_LO: begin
                // boot_skip wins over a byte presented in the same cycle
                if (boot_skip) begin
                    state_d = S_RUN;
                end else if (accept) begin
                    len_d[7:0] = rx.rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx.rx_data;
                    if (32'(new_len) > (32'd1 << AW)) begin
                        state_d = S_ERR;
                    end else if (new_len == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx.rx_data;
                    lane_cnt_d = lane_cnt_q + 2'd1;   // wraps 3 -> 0
                    if (lane_cnt_q == 2'd3) begin
                        ram_we         = 1'b1;
                        words_loaded_d = words_loaded_q + WORD_INC;
                        if (32'(words_loaded_q) + 32'd1 == 32'(len_q)) begin
                            state_d = S_CHK;
                        end
                    end else begin
                        word_buf_d[8*lane_cnt_q +: 8] = rx.rx_data;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (rx.rx_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            default: begin
                // S_RUN / S_ERR are terminal until reset
            end
        endcase

        // Status outputs are registered decodes of the next state so they
        // change on the same edge as the state itself.
        core_rst_n_d = (state_d == S_RUN);
        done_d       = (state_d == S_RUN);
        err_d        = (state_d == S_ERR);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_LEN_LO;
            len_q          <= '0;
            lane_cnt_q     <= '0;
            word_buf_q     <= '0;
            csum_q         <= '0;
            words_loaded_q <= '0;
            core_rst_n_q   <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            lane_cnt_q     <= lane_cnt_d;
            word_buf_q     <= word_buf_d;
            csum_q         <= csum_d;
            words_loaded_q <= words_loaded_d;
            core_rst_n_q   <= core_rst_n_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    imem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (words_loaded_q[AW-1:0]),
        .wdata (ram_wdata),
        .raddr (PCF[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Byte offset and bits above the RAM size are ignored: fetches wrap.
    assign unused_pcf_bits = ^{PCF[31:AW+2], PCF[1:0]};

    assign instrF       = (state_q == S_RUN) ? ram_rdata : NOP_INSTR;
    assign core_rst_n   = core_rst_n_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader. Frames are pushed through the
//   byte stream (optionally with random valid gaps); the expected outcome is
//   derived from the frame bytes by a frame-level model.
module tb_imem_boot_loader;
    import riscv_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_skip = 1'b0;
    logic [31:0] PCF = '0;
    logic [31:0] instrF;
    logic        core_rst_n;
    logic        done;
    logic        err;
    logic [AW:0] words_loaded;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (bus),
        .boot_skip    (boot_skip),
        .PCF          (PCF),
        .instrF       (instrF),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: from the bytes offered, work out how many the loader
    // takes, how it ends (0 = still loading, 1 = run, 2 = error), how many
    // words it writes, and update the model RAM.
    task automatic model_frame(input byte_q_t b, output int consumed,
                               output int status, output int words);
        int n, need;
        logic [7:0] cs;
        consumed = b.size();
        status   = 0;
        words    = 0;
        if (b.size() < 2) return;
        n = int'({b[1], b[0]});
        if (n > DEPTH) begin
            consumed = 2;
            status   = 2;
            return;
        end
        need     = 2 + 4 * n + 1;
        consumed = (b.size() < need) ? b.size() : need;
        words    = (consumed - 2) / 4;
        if (words > n) words = n;
        for (int w = 0; w < words; w++) begin
            model_mem[w]   = {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]};
            model_known[w] = 1'b1;
        end
        if (consumed == need) begin
            cs = 8'h00;
            for (int i = 2; i < need - 1; i++) cs ^= b[i];
            status = (b[need-1] == cs) ? 1 : 2;
        end
    endtask

    // Push bytes until all are taken or the loader drops rx_ready.
    task automatic send_bytes(input byte_q_t b, input bit bp, input bit skip_noise,
                              output int acc);
        int  idx    = 0;
        int  budget = b.size() * 20 + 50;
        bit  stopped = 1'b0;
        logic v;
        acc = 0;
        while (idx < b.size() && budget > 0 && !stopped) begin
            @(negedge clk);
            budget--;
            if (!bus.rx_ready) begin
                stopped = 1'b1;
            end else begin
                v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.rx_valid = v;
                bus.rx_data  = b[idx];
                if (skip_noise && idx > 0) boot_skip = 1'($urandom_range(0, 1));
                @(posedge clk);
                if (v) begin
                    idx++;
                    acc++;
                end
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        boot_skip    = 1'b0;
        if (budget == 0 && idx < b.size() && bus.rx_ready)
            check("send_budget_expired", 64'd0, 64'd1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        boot_skip    = 1'b0;
        PCF          = $urandom;
        rst          = 1'b0;
        #1;
        check({tag, ".rx_ready"},     bus.rx_ready, 1);
        check({tag, ".core_rst_n"},   core_rst_n,   0);
        check({tag, ".done"},         done,         0);
        check({tag, ".err"},          err,          0);
        check({tag, ".words_loaded"}, words_loaded, 0);
        check({tag, ".instrF"},       instrF,       NOP_INSTR);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fetch_check(input string tag, input int idx);
        logic [31:0] pc;
        @(negedge clk);
        pc = $urandom;
        pc[AW+1:2] = AW'(idx);
        PCF = pc;
        #1;
        check($sformatf("%s.instrF[%0d]", tag, idx), instrF, model_mem[idx]);
    endtask

    task automatic check_outcome(input string tag, input int acc, input int consumed,
                                 input int status, input int words);
        int idx;
        check({tag, ".accepted"},     acc,          consumed);
        check({tag, ".done"},         done,         (status == 1));
        check({tag, ".err"},          err,          (status == 2));
        check({tag, ".core_rst_n"},   core_rst_n,   (status == 1));
        check({tag, ".rx_ready"},     bus.rx_ready, (status == 0));
        check({tag, ".words_loaded"}, words_loaded, words);
        if (status == 1) begin
            for (int t = 0; t < 3 && t < words; t++) fetch_check(tag, t);
            for (int t = 0; t < 3; t++) begin
                idx = $urandom_range(0, DEPTH - 1);
                if (model_known[idx]) fetch_check(tag, idx);
            end
        end else begin
            @(negedge clk);
            PCF = $urandom;
            #1;
            check({tag, ".instrF_nop"}, instrF, NOP_INSTR);
        end
    endtask

    task automatic run_frame(input string tag, input byte_q_t b, input bit bp,
                             input bit skip_noise);
        int acc, consumed, status, words;
        do_reset({tag, ".rst"});
        send_bytes(b, bp, skip_noise, acc);
        model_frame(b, consumed, status, words);
        check_outcome(tag, acc, consumed, status, words);
    endtask

    task automatic fixed_fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        @(negedge clk);
        PCF = pc;
        #1;
        check(tag, instrF, exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byte_q_t good, bad, frame, partial;
        int acc, consumed, status, words, n;
        logic [7:0] cs;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        do_reset("reset");

        // Good load with hand-derived fetch results, including the wrap.
        good = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        run_frame("good", good, 1'b0, 1'b0);
        fixed_fetch("good.pc0",    32'h0000_0000, 32'h0050_0093);
        fixed_fetch("good.pc4",    32'h0000_0004, 32'h0010_0113);
        fixed_fetch("good.pc1004", 32'h0000_1004, 32'h0010_0113);

        // Bad checksum; trailing bytes must be refused.
        bad = good;
        bad[10] = 8'hC0;
        bad.push_back(8'hAA);
        bad.push_back(8'h55);
        run_frame("badcs", bad, 1'b0, 1'b0);

        // Oversize length: error on the second length byte, no RAM write.
        frame = '{8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame("oversize", frame, 1'b0, 1'b0);

        // Zero length.
        frame = '{8'h00, 8'h00, 8'h00};
        run_frame("zero", frame, 1'b0, 1'b0);

        // Skip: core released after exactly one edge, old program visible.
        do_reset("skip.rst");
        boot_skip = 1'b1;
        @(negedge clk);
        boot_skip = 1'b0;
        check("skip.core_rst_n", core_rst_n, 1);
        check("skip.done",       done,       1);
        check("skip.rx_ready",   bus.rx_ready, 0);
        fixed_fetch("skip.pc0", 32'h0000_0000, 32'h0050_0093);
        fixed_fetch("skip.pc4", 32'h0000_0004, 32'h0010_0113);

        // Backpressure on the good frame.
        run_frame("bp", good, 1'b1, 1'b0);
        fixed_fetch("bp.pc4", 32'h0000_0004, 32'h0010_0113);

        // Reset after five accepted bytes, then the full frame again.
        do_reset("mid.rst0");
        partial = good[0:4];
        send_bytes(partial, 1'b1, 1'b0, acc);
        model_frame(partial, consumed, status, words);
        check_outcome("mid.partial", acc, consumed, status, words);
        run_frame("mid.reload", good, 1'b1, 1'b0);

        // Largest legal frame: N = 2^AW.
        frame = '{8'h00, 8'h04};
        cs = 8'h00;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            frame.push_back(8'($urandom));
            cs ^= frame[frame.size() - 1];
        end
        frame.push_back(cs);
        run_frame("full", frame, 1'b0, 1'b0);

        // Randomized frames: random sizes, gaps, checksum corruption,
        // oversize lengths, trailing bytes and boot_skip noise after LEN_LO.
        for (int f = 0; f < 20; f++) begin
            frame.delete();
            if ($urandom_range(0, 7) == 0) n = $urandom_range(DEPTH + 1, 65535);
            else                           n = $urandom_range(0, 8);
            frame.push_back(8'(n));
            frame.push_back(8'(n >> 8));
            if (n <= DEPTH) begin
                cs = 8'h00;
                for (int i = 0; i < 4 * n; i++) begin
                    frame.push_back(8'($urandom));
                    cs ^= frame[frame.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
                frame.push_back(cs);
            end
            for (int i = $urandom_range(0, 2); i > 0; i--) frame.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", f), frame, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
